free_list: RTL and testbench

//  Physical-register free list between retire and rename. Hands out up to two

---
 rtl/free_list.sv | 121 ++++++++++++
 tb/tb_free_list.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Physical-register free list: ring of free preg tags feeding rename, refilled by retire.
// Latency: grants and tags are combinational from head; frees become allocatable the next cycle.
// Backpressure: all-or-nothing stall when requests exceed the free count; excess frees are dropped and flagged.
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
  parameter int PREG_W    = $clog2(NUM_PREGS),
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alloc_req_0,
  input  logic              alloc_req_1,
  output logic [PREG_W-1:0] alloc_preg_0,
  output logic [PREG_W-1:0] alloc_preg_1,
  output logic              alloc_gnt,
  output logic              stall,
  input  logic              free_valid_0,
  input  logic [PREG_W-1:0] free_preg_0,
  input  logic              free_valid_1,
  input  logic [PREG_W-1:0] free_preg_1,
  output logic [CNT_W-1:0]  free_count,
  output logic              overflow_err
);

  // Ring index width; DEPTH is a power of two so pointer arithmetic wraps for free.
  localparam int IDX_W = $clog2(DEPTH);

  // State
  logic [PREG_W-1:0] ring_q [DEPTH];
  logic [PREG_W-1:0] ring_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  // Allocation-side intermediates
  logic [1:0]        n_req;
  logic [CNT_W-1:0]  n_req_w;
  logic [IDX_W-1:0]  head_p1;

  // Free-side intermediates
  logic              acc_0, acc_1;
  logic              keep_0, keep_1;
  logic [CNT_W-1:0]  room;
  logic [1:0]        n_keep;
  logic [IDX_W-1:0]  tail_p1;
  logic [IDX_W-1:0]  wr1_idx;

  // Allocation decision: stall compares against the count held at the start of the cycle.
  always_comb begin
    n_req     = {1'b0, alloc_req_0} + {1'b0, alloc_req_1};
    n_req_w   = CNT_W'(n_req);
    head_p1   = head_q + IDX_W'(1);
    stall     = (n_req_w > cnt_q);
    alloc_gnt = (n_req != 2'd0) && !stall;
    alloc_preg_0 = ring_q[head_q];
    // Slot 1 takes the head tag only when it is the sole requester; otherwise
    // (including idle cycles) it previews the second tag in line.
    if (alloc_req_1 && !alloc_req_0) begin
      alloc_preg_1 = ring_q[head_q];
    end else begin
      alloc_preg_1 = ring_q[head_p1];
    end
  end

  // Free acceptance: p0 is never recycled; slot 0 wins when only one entry of room remains.
  always_comb begin
    acc_0   = free_valid_0 && (free_preg_0 != '0);
    acc_1   = free_valid_1 && (free_preg_1 != '0);
    room    = CNT_W'(DEPTH) - cnt_q;
    keep_0  = acc_0 && (room != '0);
    keep_1  = acc_1 && (keep_0 ? (room >= CNT_W'(2)) : (room != '0));
    n_keep  = {1'b0, keep_0} + {1'b0, keep_1};
    tail_p1 = tail_q + IDX_W'(1);
    wr1_idx = keep_0 ? tail_p1 : tail_q;
  end

  // Next-state: ring writes at tail, pointer advances, count and sticky overflow.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ring_d[i] = ring_q[i];
    end
    if (keep_0) begin
      ring_d[tail_q] = free_preg_0;
    end
    if (keep_1) begin
      ring_d[wr1_idx] = free_preg_1;
    end
    head_d = alloc_gnt ? (head_q + IDX_W'(n_req)) : head_q;
    tail_d = tail_q + IDX_W'(n_keep);
    cnt_d  = cnt_q - (alloc_gnt ? n_req_w : '0) + CNT_W'(n_keep);
    ovf_d  = ovf_q || (acc_0 && !keep_0) || (acc_1 && !keep_1);
  end

  // State registers; reset restores the identity mapping of the upper pregs into the ring.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= PREG_W'(NUM_AREGS + i);
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= CNT_W'(DEPTH);
      ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= ring_d[i];
      end
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign free_count   = cnt_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: stimulus queues expected outputs, a negedge monitor checks them.
// Latency: each queued expectation is checked at the negedge of the cycle it was issued in.
// Backpressure: none; the monitor drains one expectation per cycle.
module tb_free_list;

  logic       clk;
  logic       rstn;
  logic       alloc_req_0, alloc_req_1;
  logic [5:0] alloc_preg_0, alloc_preg_1;
  logic       alloc_gnt, stall;
  logic       free_valid_0, free_valid_1;
  logic [5:0] free_preg_0, free_preg_1;
  logic [5:0] free_count;
  logic       overflow_err;

  free_list dut (
    .clk          (clk),
    .rstn         (rstn),
    .alloc_req_0  (alloc_req_0),
    .alloc_req_1  (alloc_req_1),
    .alloc_preg_0 (alloc_preg_0),
    .alloc_preg_1 (alloc_preg_1),
    .alloc_gnt    (alloc_gnt),
    .stall        (stall),
    .free_valid_0 (free_valid_0),
    .free_preg_0  (free_preg_0),
    .free_valid_1 (free_valid_1),
    .free_preg_1  (free_preg_1),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  typedef struct {
    string      name;
    logic       stall;
    logic       gnt;
    logic       chk_p;
    logic [5:0] p0;
    logic [5:0] p1;
    logic [5:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  bit   done = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic apply(input logic r0, input logic r1,
                       input logic fv0, input logic [5:0] fp0,
                       input logic fv1, input logic [5:0] fp1);
    @(posedge clk);
    #1;
    alloc_req_0  = r0;
    alloc_req_1  = r1;
    free_valid_0 = fv0;
    free_preg_0  = fp0;
    free_valid_1 = fv1;
    free_preg_1  = fp1;
  endtask

  task automatic push_exp(input string nm, input logic s, input logic g,
                          input logic cp, input logic [5:0] p0, input logic [5:0] p1,
                          input logic [5:0] c, input logic o);
    exp_t e;
    e.name = nm; e.stall = s; e.gnt = g; e.chk_p = cp;
    e.p0 = p0; e.p1 = p1; e.cnt = c; e.ovf = o;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    alloc_req_0 = 0; alloc_req_1 = 0; free_valid_0 = 0; free_valid_1 = 0;
    free_preg_0 = '0; free_preg_1 = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Stimulus
  initial begin
    rstn = 1'b0;
    alloc_req_0 = 0; alloc_req_1 = 0; free_valid_0 = 0; free_valid_1 = 0;
    free_preg_0 = '0; free_preg_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // 1: reset state
    apply(0, 0, 0, 0, 0, 0);
    push_exp("s1_reset", 0, 0, 1, 6'd32, 6'd33, 6'd32, 0);

    // 2: drain with dual requests, then stall on empty
    for (int i = 0; i < 16; i++) begin
      apply(1, 1, 0, 0, 0, 0);
      push_exp($sformatf("s2_alloc%0d", i), 0, 1, 1, 6'(32 + 2*i), 6'(33 + 2*i), 6'(32 - 2*i), 0);
    end
    apply(1, 0, 0, 0, 0, 0);
    push_exp("s2_empty_stall", 1, 0, 1, 6'd32, 6'd33, 6'd0, 0);

    // 3: refill from empty with p5/p9; freeing p0 is ignored
    apply(0, 0, 1, 6'd5, 1, 6'd9);
    push_exp("s3_free_same_cycle", 0, 0, 1, 6'd32, 6'd33, 6'd0, 0);
    apply(0, 0, 1, 6'd0, 0, 0);
    push_exp("s3_refilled", 0, 0, 1, 6'd5, 6'd9, 6'd2, 0);
    apply(1, 0, 0, 0, 0, 0);
    push_exp("s3_p0_ignored", 0, 1, 1, 6'd5, 6'd9, 6'd2, 0);

    // 4: count=1 with two requests stalls; concurrent free of p7
    apply(1, 1, 1, 6'd7, 0, 0);
    push_exp("s4_stall_cnt1", 1, 0, 1, 6'd9, 6'd34, 6'd1, 0);
    apply(1, 1, 0, 0, 0, 0);
    push_exp("s4_grant_after_free", 0, 1, 1, 6'd9, 6'd7, 6'd2, 0);
    apply(0, 0, 0, 0, 0, 0);
    push_exp("s4_empty_again", 0, 0, 1, 6'd35, 6'd36, 6'd0, 0);

    // 5: free into a full ring is dropped and overflow is sticky
    do_reset();
    apply(0, 0, 0, 0, 0, 0);
    push_exp("s5_reset", 0, 0, 1, 6'd32, 6'd33, 6'd32, 0);
    apply(0, 0, 1, 6'd40, 0, 0);
    push_exp("s5_free_full", 0, 0, 1, 6'd32, 6'd33, 6'd32, 0);
    apply(0, 0, 0, 0, 0, 0);
    push_exp("s5_overflow_set", 0, 0, 1, 6'd32, 6'd33, 6'd32, 1);
    apply(1, 0, 0, 0, 0, 0);
    push_exp("s5_sticky_alloc", 0, 1, 1, 6'd32, 6'd33, 6'd32, 1);
    apply(0, 0, 0, 0, 0, 0);
    push_exp("s5_sticky_idle", 0, 0, 1, 6'd33, 6'd34, 6'd31, 1);

    // 6: walk head to index 31, single slot-1 request wraps it while frees land at 0/1
    do_reset();
    for (int i = 0; i < 15; i++) begin
      apply(1, 1, 0, 0, 0, 0);
    end
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 1, 1, 6'd12, 1, 6'd13);
    push_exp("s6_wrap_req1", 0, 1, 1, 6'd63, 6'd63, 6'd1, 0);
    apply(0, 0, 0, 0, 0, 0);
    push_exp("s6_after_wrap", 0, 0, 1, 6'd12, 6'd13, 6'd2, 0);

    // Mid-stream reset with requests asserted
    apply(1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    alloc_req_0 = 0; alloc_req_1 = 0;
    rstn = 1'b1;
    apply(0, 0, 0, 0, 0, 0);
    push_exp("s6_midstream_reset", 0, 0, 1, 6'd32, 6'd33, 6'd32, 0);

    done = 1;
  end

  // Monitor: compares one queued expectation against the DUT each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (stall !== e.stall) begin
          n_fail++;
          $display("FAIL %s.stall: got %0d, want %0d", e.name, stall, e.stall);
        end
        n_checks++;
        if (alloc_gnt !== e.gnt) begin
          n_fail++;
          $display("FAIL %s.alloc_gnt: got %0d, want %0d", e.name, alloc_gnt, e.gnt);
        end
        n_checks++;
        if (free_count !== e.cnt) begin
          n_fail++;
          $display("FAIL %s.free_count: got %0d, want %0d", e.name, free_count, e.cnt);
        end
        n_checks++;
        if (overflow_err !== e.ovf) begin
          n_fail++;
          $display("FAIL %s.overflow_err: got %0d, want %0d", e.name, overflow_err, e.ovf);
        end
        if (e.chk_p) begin
          n_checks++;
          if (alloc_preg_0 !== e.p0) begin
            n_fail++;
            $display("FAIL %s.alloc_preg_0: got %0d, want %0d", e.name, alloc_preg_0, e.p0);
          end
          n_checks++;
          if (alloc_preg_1 !== e.p1) begin
            n_fail++;
            $display("FAIL %s.alloc_preg_1: got %0d, want %0d", e.name, alloc_preg_1, e.p1);
          end
        end
      end else if (done) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

endmodule
